// File: rtl/edge_rate_generator.sv
// Purpose : evenly spaced single-cycle pulse train, N pulses per window, N given as BCD tens/units.
// Latency : rate accept -> rate_ready high = tens+2 cycles plus wait to next window boundary; signal lags its add by 1 cycle.
// Backpr. : rate_ready low while a rate is converting/pending; rate_load during that time is dropped, never queued.
//
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   period/period_load  - new window length (0 ignored), used from the next window reload
//   rate_tens/units     - BCD edges-per-window request, digits above 9 saturate to 9
//   rate_load/ready     - rate handshake
//   signal              - generated pulse train
//   overrun             - sticky flag: last accepted rate was clamped to floor(update_period/2)
//   window_start        - only with EDGE_RATE_GENERATOR_WINDOW_STROBE_EN defined: one-cycle window-start strobe
module edge_rate_generator #(
    parameter int UPDATE_PERIOD = 1200,
    parameter int BITS          = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [BITS-1:0] period,
    input  logic            period_load,
    input  logic [3:0]      rate_tens,
    input  logic [3:0]      rate_units,
    input  logic            rate_load,
    output logic            rate_ready,
    output logic            signal,
    output logic            overrun
`ifdef EDGE_RATE_GENERATOR_WINDOW_STROBE_EN
    ,
    output logic            window_start
`else
`endif
);

    localparam logic [BITS-1:0] L_UPD = BITS'(UPDATE_PERIOD);
    localparam logic [BITS-1:0] L_TEN = BITS'(10);
    localparam logic [BITS-1:0] L_ONE = BITS'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_CLAMP   = 2'd2,
        S_PENDING = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [BITS-1:0] r_update_period;
    logic [BITS-1:0] r_win_len;       // length of the window currently running
    logic [BITS-1:0] r_win_cnt;
    logic [BITS-1:0] r_acc;
    logic [BITS-1:0] r_rate;
    logic [BITS-1:0] r_bin;
    logic [3:0]      r_tens;
    logic            r_overrun;
    logic            r_signal;
    logic            r_win_start;

    logic            w_reload;
    logic [BITS:0]   w_sum;
    logic            w_ovf;
    logic [BITS-1:0] w_acc_next;
    logic [BITS-1:0] w_limit;

    function automatic logic [3:0] sat9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // Last cycle of the window: counter reloads, next cycle is a window start.
    assign w_reload   = (r_win_cnt == L_ONE);
    assign w_sum      = {1'b0, r_acc} + {1'b0, r_rate};
    assign w_ovf      = (w_sum >= {1'b0, r_win_len});
    // Result is always below r_win_len, so modulo-2^BITS arithmetic is exact.
    assign w_acc_next = w_ovf ? (r_acc + r_rate - r_win_len) : w_sum[BITS-1:0];
    assign w_limit    = {1'b0, r_update_period[BITS-1:1]};

    // Window counter and DDA. The window length is latched at reload so a
    // mid-window period_load never disturbs the running window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_update_period <= L_UPD;
            r_win_len       <= L_UPD;
            r_win_cnt       <= L_UPD;
            r_acc           <= '0;
            r_signal        <= 1'b0;
            r_win_start     <= 1'b0;
        end else begin
            if (period_load && (period != '0)) begin
                r_update_period <= period;
            end
            if (w_reload) begin
                r_win_cnt <= r_update_period;
                r_win_len <= r_update_period;
                r_acc     <= '0;
            end else begin
                r_win_cnt <= r_win_cnt - L_ONE;
                r_acc     <= w_acc_next;
            end
            r_signal    <= w_ovf;
            r_win_start <= w_reload;
        end
    end

    // Rate FSM: state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Rate FSM: next state.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (rate_load) w_next_state = S_CONVERT;
            S_CONVERT: if (r_tens == 4'd0) w_next_state = S_CLAMP;
            S_CLAMP:   w_next_state = S_PENDING;
            S_PENDING: if (w_reload) w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Rate FSM: outputs.
    always_comb begin
        rate_ready = (r_state == S_IDLE);
    end

    // Rate datapath. The new rate is committed on the window's last cycle so
    // the DDA runs the very first cycle of the new window at the new rate;
    // that keeps the per-window pulse count exact across a rate change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tens    <= 4'd0;
            r_bin     <= '0;
            r_rate    <= '0;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (rate_load) begin
                        r_tens <= sat9(rate_tens);
                        r_bin  <= {{(BITS-4){1'b0}}, sat9(rate_units)};
                    end
                end
                S_CONVERT: begin
                    if (r_tens != 4'd0) begin
                        r_bin  <= r_bin + L_TEN;
                        r_tens <= r_tens - 4'd1;
                    end
                end
                S_CLAMP: begin
                    // Above half the period two overflows could be adjacent.
                    if (r_bin > w_limit) begin
                        r_bin     <= w_limit;
                        r_overrun <= 1'b1;
                    end else begin
                        r_overrun <= 1'b0;
                    end
                end
                S_PENDING: begin
                    if (w_reload) r_rate <= r_bin;
                end
                default: ;
            endcase
        end
    end

    assign signal  = r_signal;
    assign overrun = r_overrun;
`ifdef EDGE_RATE_GENERATOR_WINDOW_STROBE_EN
    assign window_start = r_win_start;
`else
    // Strobe is still produced internally; only the port is absent.
    logic w_win_start_unused;
    assign w_win_start_unused = r_win_start;
`endif

endmodule

// File: tb/tb_edge_rate_generator.sv
module tb_edge_rate_generator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] period = '0;
    logic        period_load = 1'b0;
    logic [3:0]  rate_tens = '0;
    logic [3:0]  rate_units = '0;
    logic        rate_load = 1'b0;
    logic        rate_ready;
    logic        signal;
    logic        overrun;
`ifdef EDGE_RATE_GENERATOR_WINDOW_STROBE_EN
    logic        window_start;
`endif

    edge_rate_generator #(.UPDATE_PERIOD(1200), .BITS(12)) dut (
        .clk         (clk),
        .reset       (reset),
        .period      (period),
        .period_load (period_load),
        .rate_tens   (rate_tens),
        .rate_units  (rate_units),
        .rate_load   (rate_load),
        .rate_ready  (rate_ready),
        .signal      (signal),
        .overrun     (overrun)
`ifdef EDGE_RATE_GENERATOR_WINDOW_STROBE_EN
        ,
        .window_start(window_start)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: the window is a position/length pair and the pulse
    // pattern follows from floor((j+1)*R/P) - floor(j*R/P) for position j.
    int m_len, m_pos, m_rate, m_upd, m_sig, m_ws;
    int m_busy, m_pend, m_clamp_at, m_bin, m_ovr, m_cyc;
    int m_prev_rate, obs, first, prev_sig;

    function automatic int sat9(input int d);
        return (d > 9) ? 9 : d;
    endfunction

    task automatic model_init();
        m_len = 1200; m_pos = 0; m_rate = 0; m_upd = 1200; m_sig = 0; m_ws = 0;
        m_busy = 0; m_pend = 0; m_clamp_at = 0; m_bin = 0; m_ovr = 0; m_cyc = 0;
        m_prev_rate = 0; obs = 0; first = 1; prev_sig = 0;
    endtask

    // Advance the model across one rising edge using the inputs now driven.
    task automatic model_edge();
        int  ovf, last, apply, clamp, accept, lim, st;
        ovf    = (((m_pos + 1) * m_rate) / m_len) != ((m_pos * m_rate) / m_len);
        last   = (m_pos == m_len - 1);
        apply  = m_busy && m_pend && last;
        clamp  = m_busy && !m_pend && (m_cyc == m_clamp_at);
        accept = !m_busy && rate_load;
        m_sig  = ovf;
        m_ws   = last;
        if (last) begin
            m_prev_rate = m_rate;
            m_pos = 0;
            m_len = m_upd;
        end else begin
            m_pos++;
        end
        if (apply) begin
            m_rate = m_bin; m_busy = 0; m_pend = 0;
        end
        if (clamp) begin
            lim   = m_upd / 2;
            m_ovr = (m_bin > lim);
            if (m_bin > lim) m_bin = lim;
            m_pend = 1;
        end
        if (accept) begin
            st = sat9(int'(rate_tens));
            m_bin = 10 * st + sat9(int'(rate_units));
            m_busy = 1; m_pend = 0;
            m_clamp_at = m_cyc + st + 2;
        end
        if (period_load && period != 0) m_upd = int'(period);
        m_cyc++;
    endtask

    task automatic check_outputs();
        chk("signal", signal, m_sig);
        chk("rate_ready", rate_ready, !m_busy);
        chk("overrun", overrun, m_ovr);
        chk("no_adjacent", signal & prev_sig, 0);
`ifdef EDGE_RATE_GENERATOR_WINDOW_STROBE_EN
        chk("window_start", window_start, m_ws);
`endif
        obs += signal;
        if (m_pos == 0) begin
            if (!first) chk("pulses_per_window", obs, m_prev_rate);
            obs = 0;
            first = 0;
        end
        prev_sig = signal;
    endtask

    task automatic cyc(input logic rl, input int t, input int u, input logic pl, input int p);
        rate_load = rl; rate_tens = t[3:0]; rate_units = u[3:0];
        period_load = pl; period = p[11:0];
        model_edge();
        @(negedge clk);
        rate_load = 1'b0; period_load = 1'b0;
        check_outputs();
    endtask

    task automatic run(input int n);
        repeat (n) cyc(1'b0, 0, 0, 1'b0, 0);
    endtask

    task automatic wait_idle();
        int g = 0;
        while (m_busy && g < 3000) begin run(1); g++; end
        chk("idle_reached", rate_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_init();
        check_outputs();                      // reset state
        run(1210);                            // default window, rate 0

        cyc(1'b0, 0, 0, 1'b1, 100);           // period 100
        cyc(1'b1, 3, 7, 1'b0, 0);             // 37 pulses per window
        run(1700);

        cyc(1'b1, 0, 0, 1'b0, 0);             // rate 0
        run(400);

        cyc(1'b0, 0, 0, 1'b1, 20);
        cyc(1'b1, 1, 5, 1'b0, 0);             // clamps to 10
        run(150);
        cyc(1'b1, 0, 4, 1'b0, 0);             // 4, overrun clears
        run(100);

        cyc(1'b0, 0, 0, 1'b1, 1200);
        cyc(1'b1, 12, 15, 1'b0, 0);           // saturates to 99
        run(3650);

        cyc(1'b1, 5, 0, 1'b0, 0);             // 50
        cyc(1'b1, 9, 9, 1'b0, 0);             // ignored during conversion
        run(3);
        cyc(1'b1, 2, 2, 1'b0, 0);             // ignored
        run(300);
        cyc(1'b0, 0, 0, 1'b1, 300);           // mid-window period change
        run(1850);

        for (int k = 0; k < 6; k++) begin
            wait_idle();
            if ($urandom_range(0, 1) == 1)
                cyc(1'b0, 0, 0, 1'b1, int'($urandom_range(200, 400)));
            run(int'($urandom_range(0, 50)));
            cyc(1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b0, 0);
            if ($urandom_range(0, 1) == 1)
                cyc(1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b0, 0);
            run(int'($urandom_range(300, 900)));
        end

        // Reset in the middle of a window while a pulse is high.
        wait_idle();
        cyc(1'b0, 0, 0, 1'b1, 20);
        cyc(1'b1, 1, 5, 1'b0, 0);
        g = 0;
        while (!(m_busy == 0 && m_sig == 1) && g < 3000) begin run(1); g++; end
        chk("pulse_before_reset", signal, 1);
        chk("overrun_before_reset", overrun, 1);
        #1 reset = 1'b1;
        #1;
        chk("rst_signal", signal, 0);
        chk("rst_rate_ready", rate_ready, 1);
        chk("rst_overrun", overrun, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_init();
        check_outputs();
        run(1250);                            // default window, 0 pulses

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
